// File: rtl/multicycle_datapath_pkg.sv
// Shared types for the multicycle datapath: FSM states, ALU op codes, latched control word.
// Optional performance counters are enabled in the top level by defining MCDP_PERF_CNT_EN.
package mcdp_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_NOT = 3'b010,
    ALU_SLL = 3'b011,
    ALU_SRL = 3'b100,
    ALU_AND = 3'b101,
    ALU_OR  = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  // Control strobes captured once in DECODE and held for the rest of the instruction
  typedef struct packed {
    logic    jump;
    logic    beq;
    logic    bne;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    reg_write;
    alu_op_t alu_cnt;
  } ctrl_t;

endpackage

// File: rtl/multicycle_datapath_alu.sv
// Combinational ALU for the multicycle datapath; result truncates to DATA_W.
module mcdp_alu
  import mcdp_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_op_t           i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);

  localparam int SH_W = $clog2(DATA_W);

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_NOT: o_result = ~i_a;
      ALU_SLL: o_result = i_a << i_b[SH_W-1:0];
      ALU_SRL: o_result = i_a >> i_b[SH_W-1:0];
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_SLT: o_result = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle RISC datapath: FETCH/DECODE/EXEC/MEM/WB with req/ack memory ports.
// Define MCDP_PERF_CNT_EN to add the cycle_cnt / instr_cnt performance counters.
module multicycle_datapath
  import mcdp_pkg::*;
#(
  parameter int               DATA_W   = 16,
  parameter int               NREGS    = 8,
  parameter logic [PC_W-1:0]  PC_RESET = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [15:0]        dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic [3:0]         opcode,
  input  logic               jump,
  input  logic               beq,
  input  logic               bne,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               alu_src,
  input  logic               reg_dst,
  input  logic               mem_to_reg,
  input  logic               reg_write,
  input  logic [2:0]         alu_cnt,
  output logic [PC_W-1:0]    pc,
  output logic               retire
`ifdef MCDP_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt
`endif
);

  localparam int RA_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic [DATA_W-1:0]   r_a, r_b, r_aluout, r_mdr;
  ctrl_t               r_ctrl;
  logic                r_imem_req, r_dmem_req, r_dmem_we;
  logic [DATA_W-1:0]   r_regs [NREGS];

  logic [DATA_W-1:0]   w_imm, w_alu_b, w_alu_res, w_wr_data;
  logic                w_zero, w_taken, w_retire;
  logic [PC_W-1:0]     w_pc2, w_flow_pc;
  logic [RA_W-1:0]     w_rs, w_rt, w_wr_addr;

  assign w_imm     = {{(DATA_W-6){r_ir[5]}}, r_ir[5:0]};
  assign w_alu_b   = r_ctrl.alu_src ? w_imm : r_b;
  assign w_rs      = r_ir[9 +: RA_W];
  assign w_rt      = r_ir[6 +: RA_W];
  assign w_wr_addr = r_ctrl.reg_dst ? r_ir[3 +: RA_W] : w_rt;
  assign w_wr_data = r_ctrl.mem_to_reg ? r_mdr : r_aluout;

  mcdp_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op     (r_ctrl.alu_cnt),
    .i_a      (r_a),
    .i_b      (w_alu_b),
    .o_result (w_alu_res),
    .o_zero   (w_zero)
  );

  // Next PC for control-flow instructions: jump keeps the top three bits of pc+2
  assign w_pc2     = r_pc + 16'd2;
  assign w_taken   = (r_ctrl.beq & w_zero) | (r_ctrl.bne & ~w_zero);
  assign w_flow_pc = r_ctrl.jump ? {w_pc2[15:13], r_ir[11:0], 1'b0} :
                     w_taken     ? w_pc2 + {{9{r_ir[5]}}, r_ir[5:0], 1'b0} :
                                   w_pc2;

  assign w_retire = ~rst & ((r_state == WB) |
                            ((r_state == EXEC) & (r_ctrl.jump | r_ctrl.beq | r_ctrl.bne)) |
                            ((r_state == MEM) & r_dmem_req & dmem_ack & r_dmem_we));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH;
      r_pc       <= PC_RESET;
      r_ir       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_aluout   <= '0;
      r_mdr      <= '0;
      r_ctrl     <= '0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          // The first FETCH after reset spends one cycle raising the request
          if (!r_imem_req) begin
            r_imem_req <= 1'b1;
          end else if (imem_ack) begin
            r_ir       <= imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= DECODE;
          end
        end
        DECODE: begin
          r_a     <= r_regs[w_rs];
          r_b     <= r_regs[w_rt];
          r_ctrl  <= {jump, beq, bne, mem_read, mem_write, alu_src,
                      reg_dst, mem_to_reg, reg_write, alu_cnt};
          r_state <= EXEC;
        end
        EXEC: begin
          r_aluout <= w_alu_res;
          if (r_ctrl.jump | r_ctrl.beq | r_ctrl.bne) begin
            r_pc       <= w_flow_pc;
            r_imem_req <= 1'b1;
            r_state    <= FETCH;
          end else begin
            r_pc <= w_pc2;
            if (r_ctrl.mem_read | r_ctrl.mem_write) begin
              r_dmem_req <= 1'b1;
              r_dmem_we  <= r_ctrl.mem_write;
              r_state    <= MEM;
            end else begin
              r_state <= WB;
            end
          end
        end
        MEM: begin
          if (r_dmem_req & dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (r_dmem_we) begin
              r_imem_req <= 1'b1;
              r_state    <= FETCH;
            end else begin
              r_mdr   <= dmem_rdata;
              r_state <= WB;
            end
          end
        end
        WB: begin
          if (r_ctrl.reg_write) r_regs[w_wr_addr] <= w_wr_data;
          r_imem_req <= 1'b1;
          r_state    <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_aluout[15:0];
  assign dmem_wdata = r_b;
  assign opcode     = r_ir[15:12];
  assign retire     = w_retire;

`ifdef MCDP_PERF_CNT_EN
  logic [31:0] r_cycle_cnt, r_instr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench for multicycle_datapath: an ISA-level model predicts each
// instruction's PC, latency and data-memory transaction; results are popped on retire.
`timescale 1ns/1ps
module tb_multicycle_datapath;

   localparam logic [15:0] PC_RST = 16'h0010;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_ack;
   logic [15:0] imem_addr, imem_rdata;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  opcode;
   logic        jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write;
   logic [2:0]  alu_cnt;
   logic [15:0] pc;
   logic        retire;
`ifdef MCDP_PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   typedef struct packed {
      logic       jump, beq, bne, memRead, memWrite, aluSrc, regDst, memToReg, regWrite;
      logic [2:0] aluCnt;
   } tbCtrl_t;

   typedef struct {
      logic [15:0] pc;
      int          cycles;
      bit          isMem;
      logic [15:0] addr;
      bit          we;
      logic [15:0] wdata;
   } expT;

   tbCtrl_t     tbCtrl;
   logic [15:0] mRegs [8];
   logic [15:0] mPc;
   expT         expQ [$];
   int          checks = 0;
   int          errors = 0;

   multicycle_datapath #(.DATA_W(16), .NREGS(8), .PC_RESET(PC_RST)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .opcode(opcode),
      .jump(jump), .beq(beq), .bne(bne), .mem_read(mem_read), .mem_write(mem_write),
      .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_cnt(alu_cnt),
      .pc(pc), .retire(retire)
`ifdef MCDP_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Bench control unit: 0-7 R-type ALU, 8 addi, 9 load, A store, B beq, C bne, D jump
   function automatic tbCtrl_t decodeOp(input logic [3:0] op);
      tbCtrl_t c;
      c = '0;
      if (!op[3]) begin
         c.aluCnt = op[2:0]; c.regDst = 1'b1; c.regWrite = 1'b1;
      end else begin
         case (op)
            4'h8: begin c.aluSrc = 1'b1; c.regWrite = 1'b1; end
            4'h9: begin c.memRead = 1'b1; c.aluSrc = 1'b1; c.memToReg = 1'b1; c.regWrite = 1'b1; end
            4'hA: begin c.memWrite = 1'b1; c.aluSrc = 1'b1; end
            4'hB: begin c.beq = 1'b1; c.aluCnt = 3'b001; end
            4'hC: begin c.bne = 1'b1; c.aluCnt = 3'b001; end
            4'hD: c.jump = 1'b1;
            default: ;
         endcase
      end
      return c;
   endfunction

   always_comb tbCtrl = decodeOp(opcode);
   assign jump = tbCtrl.jump;          assign beq = tbCtrl.beq;
   assign bne = tbCtrl.bne;            assign mem_read = tbCtrl.memRead;
   assign mem_write = tbCtrl.memWrite; assign alu_src = tbCtrl.aluSrc;
   assign reg_dst = tbCtrl.regDst;     assign mem_to_reg = tbCtrl.memToReg;
   assign reg_write = tbCtrl.regWrite; assign alu_cnt = tbCtrl.aluCnt;

   function automatic logic [15:0] aluModel(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return ~a;
         3'd3: return a << b[3:0];
         3'd4: return a >> b[3:0];
         3'd5: return a & b;
         3'd6: return a | b;
         default: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      endcase
   endfunction

   function automatic logic [15:0] rType(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
      return {1'b0, op, rs, rt, rd, 3'b000};
   endfunction

   function automatic logic [15:0] iType(input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt, input logic [5:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [15:0] jType(input logic [11:0] tgt);
      return {4'hD, tgt};
   endfunction

   // Every comparison funnels through here
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   // Predict one instruction, push the expectation, then serve the memory ports until retire
   task automatic applyStimulus(input string tag, input logic [15:0] instr,
                                input int iWait, input int dWait, input logic [15:0] rdData);
      expT         e;
      tbCtrl_t     c;
      logic [15:0] a, b, imm, res, pc2;
      logic [15:0] firstAddr;
      bit          taken, started, gotRetire;
      int          k, iw, dw, dReqCycles;

      c   = decodeOp(instr[15:12]);
      a   = mRegs[instr[11:9]];
      b   = mRegs[instr[8:6]];
      imm = {{10{instr[5]}}, instr[5:0]};
      res = aluModel(c.aluCnt, a, c.aluSrc ? imm : b);
      pc2 = mPc + 16'd2;
      e.isMem = 1'b0; e.addr = '0; e.we = 1'b0; e.wdata = '0;
      if (c.jump) begin
         e.pc = {pc2[15:13], instr[11:0], 1'b0};
         e.cycles = 3;
      end else if (c.beq || c.bne) begin
         taken = (c.beq && res == 16'd0) || (c.bne && res != 16'd0);
         e.pc = taken ? pc2 + {imm[14:0], 1'b0} : pc2;
         e.cycles = 3;
      end else begin
         e.pc = pc2;
         if (c.memRead || c.memWrite) begin
            e.isMem = 1'b1; e.addr = res; e.we = c.memWrite; e.wdata = b;
            e.cycles = c.memWrite ? 4 : 5;
         end else begin
            e.cycles = 4;
         end
         if (c.regWrite) mRegs[c.regDst ? instr[5:3] : instr[8:6]] = c.memToReg ? rdData : res;
      end
      e.cycles += iWait + (e.isMem ? dWait : 0);
      mPc = e.pc;
      expQ.push_back(e);

      iw = iWait; dw = dWait; k = 0; dReqCycles = 0;
      started = 1'b0; gotRetire = 1'b0; firstAddr = '0;
      for (int t = 0; t < 64 && !gotRetire; t++) begin
         if (imem_req) begin
            started = 1'b1;
            if (iw == 0) begin imem_ack = 1'b1; imem_rdata = instr; end
            else begin iw--; imem_ack = 1'b0; imem_rdata = 16'($urandom); end
         end else begin
            imem_ack = 1'($urandom_range(0, 1)); imem_rdata = 16'($urandom);
         end
         if (dmem_req) begin
            if (!expQ[0].isMem) checkOutput($sformatf("%s unexpected dmem_req", tag), 1, 0);
            else if (dReqCycles == 0) begin
               firstAddr = dmem_addr;
               checkOutput($sformatf("%s dmem_addr", tag), dmem_addr, expQ[0].addr);
               checkOutput($sformatf("%s dmem_we", tag), dmem_we, expQ[0].we);
               if (expQ[0].we) checkOutput($sformatf("%s dmem_wdata", tag), dmem_wdata, expQ[0].wdata);
            end else begin
               checkOutput($sformatf("%s dmem_addr stable", tag), dmem_addr, firstAddr);
            end
            dReqCycles++;
            if (dw == 0) begin dmem_ack = 1'b1; dmem_rdata = rdData; end
            else begin dw--; dmem_ack = 1'b0; dmem_rdata = 16'($urandom); end
         end else begin
            dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = 16'($urandom);
         end
         if (started) k++;
         @(negedge clk);
         if (retire) gotRetire = 1'b1;
         @(posedge clk); #1;
      end

      if (!gotRetire) checkOutput($sformatf("%s retire timeout", tag), 0, 1);
      e = expQ.pop_front();
      if (gotRetire) begin
         checkOutput($sformatf("%s latency", tag), k, e.cycles);
         checkOutput($sformatf("%s pc", tag), pc, e.pc);
         if (e.isMem) checkOutput($sformatf("%s dmem_req cycles", tag), dReqCycles, dWait + 1);
      end
   endtask

   // Read a register back through a store from address 0 + 0
   task automatic checkReg(input int r);
      logic [2:0] rr;
      rr = r[2:0];
      applyStimulus($sformatf("R%0d readback", r), iType(4'hA, 3'd0, rr, 6'd0), 0, 0, 16'h0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int waited;
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      for (int i = 0; i < 8; i++) mRegs[i] = '0;
      mPc = PC_RST;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset pc", pc, PC_RST);
      checkOutput("reset imem_req", imem_req, 0);
      checkOutput("reset dmem_req", dmem_req, 0);
      checkOutput("reset dmem_we", dmem_we, 0);
      checkOutput("reset retire", retire, 0);
      checkOutput("reset opcode", opcode, 0);
      checkOutput("reset dmem_addr", dmem_addr, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("post-reset imem_req", imem_req, 1);
      checkOutput("post-reset imem_addr", imem_addr, PC_RST);

      checkReg(3);
      checkReg(7);

      applyStimulus("addi R1=5", iType(4'h8, 3'd0, 3'd1, 6'd5), 1, 0, 16'h0);
      applyStimulus("addi R2=3", iType(4'h8, 3'd0, 3'd2, 6'd3), 0, 0, 16'h0);
      applyStimulus("sub R3", rType(3'd1, 3'd1, 3'd2, 3'd3), 0, 0, 16'h0);
      checkReg(3);

      applyStimulus("addi R1=16", iType(4'h8, 3'd0, 3'd1, 6'd16), 0, 0, 16'h0);
      applyStimulus("add R1=R1+R1", rType(3'd0, 3'd1, 3'd1, 3'd1), 2, 0, 16'h0);
      applyStimulus("load R4", iType(4'h9, 3'd1, 3'd4, 6'd4), 0, 3, 16'hBEEF);
      checkReg(4);
      applyStimulus("store R4 wait", iType(4'hA, 3'd1, 3'd4, 6'h3F), 1, 2, 16'h0);

      applyStimulus("jump 0x40", jType(12'h020), 0, 0, 16'h0);
      applyStimulus("beq taken", iType(4'hB, 3'd1, 3'd1, 6'h3E), 0, 0, 16'h0);
      checkOutput("beq target", pc, 16'h003E);
      applyStimulus("jump 0x40 again", jType(12'h020), 0, 0, 16'h0);
      applyStimulus("bne not taken", iType(4'hC, 3'd1, 3'd1, 6'h3E), 0, 0, 16'h0);
      checkOutput("bne fallthrough", pc, 16'h0042);
      applyStimulus("bne taken", iType(4'hC, 3'd1, 3'd2, 6'd3), 1, 0, 16'h0);
      applyStimulus("beq not taken", iType(4'hB, 3'd1, 3'd2, 6'd3), 0, 0, 16'h0);

      applyStimulus("addi R5=-7", iType(4'h8, 3'd0, 3'd5, 6'h39), 0, 0, 16'h0);
      for (int n = 0; n < 12; n++) begin
         logic [2:0] op, rs, rt, rd;
         op = 3'($urandom_range(0, 7)); rs = 3'($urandom_range(0, 7));
         rt = 3'($urandom_range(0, 7)); rd = 3'($urandom_range(1, 7));
         applyStimulus($sformatf("alu%0d op%0d", n, op), rType(op, rs, rt, rd), $urandom_range(0, 2), 0, 16'h0);
      end
      for (int r = 1; r < 8; r++) checkReg(r);

      applyStimulus("jump 0x0000", jType(12'h000), 0, 0, 16'h0);
      applyStimulus("beq back", iType(4'hB, 3'd0, 3'd0, 6'h20), 0, 0, 16'h0);
      applyStimulus("jump 0xFFFE", jType(12'hFFF), 0, 0, 16'h0);
      applyStimulus("alu at 0xFFFE", iType(4'h8, 3'd0, 3'd6, 6'd1), 0, 0, 16'h0);
      checkOutput("pc wrap", pc, 16'h0000);
      applyStimulus("jump 0x1FFE", jType(12'hFFF), 0, 0, 16'h0);
      applyStimulus("alu at 0x1FFE", iType(4'h8, 3'd0, 3'd6, 6'd2), 0, 0, 16'h0);
      checkOutput("pc 0x2000", pc, 16'h2000);
      applyStimulus("jump 0x123", jType(12'h123), 0, 0, 16'h0);
      checkOutput("jump target", pc, 16'h2246);

      // Abort a load stuck in MEM with reset
      imem_ack = 1'b1; imem_rdata = iType(4'h9, 3'd0, 3'd5, 6'd2); dmem_ack = 1'b0; dmem_rdata = 16'h1234;
      waited = 0;
      do begin
         @(posedge clk); #1;
         imem_ack = 1'b0; dmem_ack = 1'b0;
         waited++;
      end while (!dmem_req && waited < 10);
      checkOutput("abort reached MEM", dmem_req, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort dmem_req", dmem_req, 0);
      checkOutput("abort imem_req", imem_req, 0);
      checkOutput("abort pc", pc, PC_RST);
      checkOutput("abort retire", retire, 0);
`ifdef MCDP_PERF_CNT_EN
      checkOutput("abort cycle_cnt", cycle_cnt, 0);
      checkOutput("abort instr_cnt", instr_cnt, 0);
`endif
      rst = 1'b0;
      for (int i = 0; i < 8; i++) mRegs[i] = '0;
      mPc = PC_RST;
      @(posedge clk); #1;
      checkOutput("abort refetch imem_req", imem_req, 1);
      checkOutput("abort refetch addr", imem_addr, PC_RST);
`ifdef MCDP_PERF_CNT_EN
      checkOutput("cycle_cnt first", cycle_cnt, 1);
`endif
      checkReg(5);
`ifdef MCDP_PERF_CNT_EN
      checkOutput("instr_cnt one", instr_cnt, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multicycle successor to the single-cycle RISC datapath.
- Keeps the same 16-bit instruction encoding and the external control-unit split: opcode goes out, control strobes come in.
- Adds a state machine, a data width set by `DATA_W`, separate req/ack instruction and data memory ports with wait states, synchronous reset, and a registered PC.

Parameters:
- `DATA_W`, 16, register/ALU/data width (≥16).
- `NREGS`, 8, register count (power of two, ≤8; the address fields are 3 bits and the upper bits are ignored when `NREGS`<8).
- `PC_RESET`, 16'h0000, PC value after reset.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  16  fetch address (= PC).
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid.
- `imem_rdata`  in  16  instruction word.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  16  ALU result [15:0].
- `dmem_wdata`  out  DATA_W  store data (rs2 value).
- `dmem_rdata`  in  DATA_W  load data.
- `dmem_ack`  in  1  access complete.
- `opcode`  out  4  IR[15:12] to the control unit.
- `jump`, `beq`, `bne`, `mem_read`, `mem_write`, `alu_src`, `reg_dst`, `mem_to_reg`, `reg_write`  in  1 each  control strobes, sampled in DECODE.
- `alu_cnt`  in  3  ALU operation, sampled in DECODE.
- `pc`  out  16  current PC.
- `retire`  out  1  one-cycle pulse when an instruction completes.

Behaviour:
- Reset (`rst` high at a clock edge):
  - `pc`=`PC_RESET`, IR=0, all registers=0, state=FETCH.
  - All outputs low except `pc` and `imem_addr`.
  - Reset aborts any transaction in progress; `imem_req`/`dmem_req` drop at that same edge.
- States: FETCH, DECODE, EXEC, MEM, WB.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`: IR<=`imem_rdata`, go to DECODE.
  - Otherwise hold, with `req` held high.
- DECODE:
  - A<=R[IR[11:9]], B<=R[IR[8:6]].
  - Latch all control inputs and `alu_cnt`.
  - `opcode` is valid for the whole instruction from DECODE onwards.
- EXEC:
  - ALUOUT<=op(A, `alu_src` ? sext(IR[5:0]) : B).
  - zero = (result==0).
  - pc2 = pc+2, modulo 2^16 (16'hFFFE wraps to 0).
  - If `jump`: pc<={pc2[15:13], IR[11:0], 1'b0}, `retire`, go to FETCH.
  - Else if (`beq`&zero) or (`bne`&~zero): pc<=pc2+(sext(IR[5:0])<<1), `retire`, go to FETCH.
  - Else if `beq`|`bne` (not taken): pc<=pc2, `retire`, go to FETCH.
  - Else: pc<=pc2, then MEM if `mem_read`|`mem_write`, otherwise WB.
- MEM:
  - `dmem_req`=1, `dmem_we`=`mem_write`.
  - Address and data are stable while `req` is high.
  - On `dmem_ack`: a load latches `dmem_rdata` into MDR and goes to WB; a store asserts `retire` and goes to FETCH.
- WB:
  - If `reg_write`: R[`reg_dst` ? IR[5:3] : IR[8:6]] <= `mem_to_reg` ? MDR : ALUOUT.
  - Assert `retire`, go to FETCH.
- Minimum latency with ack in the same cycle as req: ALU 4 cycles, load 5, store 4, branch/jump 3. Each wait cycle adds 1.
- Handshake rules:
  - `ack` is ignored when the matching `req` is low.
  - `req` deasserts in the cycle after `ack` is sampled.
- ALU operations (`alu_cnt`):
  - 000 add, 001 sub, 010 ~a, 011 a<<b[log2 DATA_W-1:0], 100 a>>b (logical).
  - 101 and, 110 or, 111 slt (signed, result 1 or 0).
  - Results truncate to `DATA_W`.
- `sext` extends IR[5] to `DATA_W`.
- Register reads in DECODE always see completed WB writes, because there is no overlap between instructions.

Optional Feature:
- Macro: `MCDP_PERF_CNT_EN`.
- When defined, adds outputs `cycle_cnt` [31:0] and `instr_cnt` [31:0]:
  - `cycle_cnt` increments every non-reset cycle.
  - `instr_cnt` increments on `retire`.
  - Both clear on `rst` and wrap at 2^32.
- When undefined, neither port nor its logic exists.

Decomposition:
- Shared package `mcdp_pkg`:
  - State enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
  - ALU op codes.
  - `INSTR_W`=16, `PC_W`=16.
- One sub-module, `mcdp_alu`: combinational, parametrised by `DATA_W`, produces result and zero.
- Register file inline.

Test Plan:
- Reset with `PC_RESET`=16'h0010, `rst` high for 2 cycles -> `pc`=0x0010, `imem_req`=0, all registers 0. After release, `imem_req`=1 with `imem_addr`=0x0010.
- ALU op with R1=5, R2=3, `alu_cnt`=001, `reg_dst`=1, dest R3, zero-wait acks -> R3=2, `retire` in cycle 4, `pc`+=2.
- Load with 3 wait cycles on `dmem_ack`, R1=0x20, imm=4, `dmem_rdata`=0xBEEF -> `dmem_addr`=0x24 held for 4 cycles, R[IR[8:6]]=0xBEEF, total 8 cycles.
- Branch with `beq`, A==B, imm=6'h3E (-2), pc=0x0040 -> pc=0x003E. With `bne` and the same operands -> pc=0x0042.
- Wrap and jump: pc=0xFFFE running an ALU op -> pc=0x0000. `jump` with IR[11:0]=0x123 at pc=0x2000 -> pc=0x2246.
- `rst` asserted during MEM with `dmem_ack` low -> `dmem_req`=0 next cycle, no register write, state=FETCH. Perf counters (macro on) read 0.
